// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the M->W payload type.
package y86_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 4;
    localparam int unsigned REG_W   = 4;

    // Instruction codes
    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    // Instruction status codes
    localparam logic [STAT_W-1:0] S_AOK = 4'h1;
    localparam logic [STAT_W-1:0] S_HLT = 4'h2;
    localparam logic [STAT_W-1:0] S_ADR = 4'h3;
    localparam logic [STAT_W-1:0] S_INS = 4'h4;

    // "No register" id
    localparam logic [REG_W-1:0] R_NONE = 4'hF;

    typedef struct packed {
        logic [STAT_W-1:0]  status;
        logic [ICODE_W-1:0] icode;
        logic [WORD_W-1:0]  valE;
        logic [WORD_W-1:0]  valM;
        logic [REG_W-1:0]   dstE;
        logic [REG_W-1:0]   dstM;
    } wRegT;

    // Contents of W after reset or a bubble: a harmless nop
    localparam wRegT W_BUBBLE = '{
        status: S_AOK,
        icode:  I_NOP,
        valE:   '0,
        valM:   '0,
        dstE:   R_NONE,
        dstM:   R_NONE
    };

    // True for statuses that stop the machine once they reach writeback
    function automatic logic isFault(input logic [STAT_W-1:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// M-register inputs, W-register controls and stage outputs of the memory stage.
interface memory_stage_if;
    import y86_pkg::*;

    logic [STAT_W-1:0]  m_status;
    logic [ICODE_W-1:0] m_icode;
    logic [ICODE_W-1:0] m_ifun;
    logic [WORD_W-1:0]  m_valE;
    logic [WORD_W-1:0]  m_valA;
    logic [WORD_W-1:0]  m_valP;
    logic [REG_W-1:0]   m_dstE;
    logic [REG_W-1:0]   m_dstM;
    logic               w_stall;
    logic               w_bubble;

    logic [WORD_W-1:0]  mem_valM;
    logic [STAT_W-1:0]  mem_stat;
    logic [STAT_W-1:0]  w_status;
    logic [ICODE_W-1:0] w_icode;
    logic [WORD_W-1:0]  w_valE;
    logic [WORD_W-1:0]  w_valM;
    logic [REG_W-1:0]   w_dstE;
    logic [REG_W-1:0]   w_dstM;

    modport master (
        output m_status, m_icode, m_ifun, m_valE, m_valA, m_valP, m_dstE, m_dstM,
        output w_stall, w_bubble,
        input  mem_valM, mem_stat, w_status, w_icode, w_valE, w_valM, w_dstE, w_dstM
    );

    modport slave (
        input  m_status, m_icode, m_ifun, m_valE, m_valA, m_valP, m_dstE, m_dstM,
        input  w_stall, w_bubble,
        output mem_valM, mem_stat, w_status, w_icode, w_valE, w_valM, w_dstE, w_dstM
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Byte-addressed data memory: 8-byte little-endian combinational read,
// 8-byte synchronous write, out-of-range flag. Contents survive reset.
module data_mem #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned AW        = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          accessEn,
    input  logic          writeEn,
    input  logic [63:0]   wrData,
    output logic [63:0]   rdData,
    output logic          error
);

    localparam int unsigned   IW        = $clog2(MEM_BYTES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_BYTES - 8);

    logic [7:0]    mem [MEM_BYTES];
    logic [IW-1:0] base;

    assign base = addr[IW-1:0];

    // Full-width unsigned compare, so huge addresses never wrap into range
    assign error = accessEn && (addr > LAST_ADDR);

    // Assemble the little-endian word starting at base
    always_comb begin
        rdData = '0;
        for (int k = 0; k < 8; k++) begin
            rdData[8*k +: 8] = mem[IW'(base + IW'(k))];
        end
    end

    // Store the word at the edge; an edge seen while in reset stores nothing
    always_ff @(posedge clk) begin
        if (rst_n && writeEn) begin
            for (int k = 0; k < 8; k++) begin
                mem[IW'(base + IW'(k))] <= wrData[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: data-memory access decode, final status, M->W register.
module memory_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned AW        = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_stage_if.slave  bus
);

    logic              readEn;
    logic              writeEn;
    logic              dmemError;
    logic              writeCommit;
    logic [AW-1:0]     memAddr;
    logic [WORD_W-1:0] wrData;
    logic [WORD_W-1:0] rdData;
    logic [WORD_W-1:0] memValM;
    logic [STAT_W-1:0] memStat;
    wRegT              wReg;
    wRegT              wNext;
    logic              unusedIfun;

    // Function code plays no part in memory access
    assign unusedIfun = ^bus.m_ifun;

    // Decode access type, address source and write data from icode
    always_comb begin
        readEn  = 1'b0;
        writeEn = 1'b0;
        memAddr = '0;
        wrData  = bus.m_valA;
        case (bus.m_icode)
            I_RMMOVQ, I_PUSHQ: begin
                writeEn = 1'b1;
                memAddr = AW'(bus.m_valE);
            end
            I_CALL: begin
                writeEn = 1'b1;
                memAddr = AW'(bus.m_valE);
                wrData  = bus.m_valP;
            end
            I_MRMOVQ: begin
                readEn  = 1'b1;
                memAddr = AW'(bus.m_valE);
            end
            I_RET, I_POPQ: begin
                readEn  = 1'b1;
                memAddr = AW'(bus.m_valA);
            end
            default: ;
        endcase
    end

    data_mem #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_dataMem (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (memAddr),
        .accessEn (readEn | writeEn),
        .writeEn  (writeCommit),
        .wrData   (wrData),
        .rdData   (rdData),
        .error    (dmemError)
    );

    // Stores only from a healthy instruction while writeback is not faulted
    assign writeCommit = writeEn && !dmemError && (bus.m_status == S_AOK) && !isFault(wReg.status);

    // Forwarding value and stage status
    assign memValM = (readEn && !dmemError) ? rdData : '0;
    assign memStat = dmemError ? S_ADR : bus.m_status;

    // Payload presented to the W register on a normal load
    always_comb begin
        wNext        = W_BUBBLE;
        wNext.status = memStat;
        wNext.icode  = bus.m_icode;
        wNext.valE   = bus.m_valE;
        wNext.valM   = memValM;
        wNext.dstE   = bus.m_dstE;
        wNext.dstM   = bus.m_dstM;
    end

    // W register: reset, then bubble, then stall, then load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wReg <= W_BUBBLE;
        end else if (bus.w_bubble) begin
            wReg <= W_BUBBLE;
        end else if (!bus.w_stall) begin
            wReg <= wNext;
        end
    end

    assign bus.mem_valM = memValM;
    assign bus.mem_stat = memStat;
    assign bus.w_status = wReg.status;
    assign bus.w_icode  = wReg.icode;
    assign bus.w_valE   = wReg.valE;
    assign bus.w_valM   = wReg.valM;
    assign bus.w_dstE   = wReg.dstE;
    assign bus.w_dstM   = wReg.dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic against a byte-array model.
module tb_memory_stage;
    import y86_pkg::*;

    localparam int unsigned MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_stage_if bus ();

    memory_stage #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: memory bytes and the W register as the specification describes them
    logic [7:0]  refMem [MEM_BYTES];
    logic [3:0]  rStat, rIcode, rDstE, rDstM;
    logic [63:0] rValE, rValM;

    logic [3:0] icodeList [12];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refRead(input logic [63:0] a);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = refMem[int'(a) + k];
        return v;
    endfunction

    task automatic refResetW();
        rStat = S_AOK; rIcode = I_NOP; rValE = '0; rValM = '0; rDstE = R_NONE; rDstM = R_NONE;
    endtask

    task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] vE,
                         input logic [63:0] vA, input logic [63:0] vP, input logic [3:0] dE,
                         input logic [3:0] dM, input logic stall, input logic bubble);
        bus.m_status = st; bus.m_icode = ic; bus.m_ifun = 4'($urandom_range(0, 15));
        bus.m_valE = vE; bus.m_valA = vA; bus.m_valP = vP;
        bus.m_dstE = dE; bus.m_dstM = dM; bus.w_stall = stall; bus.w_bubble = bubble;
    endtask

    task automatic checkW(input string tag);
        check({tag, ".w_status"}, 64'(bus.w_status), 64'(rStat));
        check({tag, ".w_icode"},  64'(bus.w_icode),  64'(rIcode));
        check({tag, ".w_valE"},   bus.w_valE,        rValE);
        check({tag, ".w_valM"},   bus.w_valM,        rValM);
        check({tag, ".w_dstE"},   64'(bus.w_dstE),   64'(rDstE));
        check({tag, ".w_dstM"},   64'(bus.w_dstM),   64'(rDstM));
    endtask

    // Called just after inputs were driven at a falling edge; returns at the next falling edge
    task automatic stepCheck(input string tag);
        logic        rd, wr, err, com;
        logic [63:0] a, expM, wd;
        logic [3:0]  expStat;
        rd = bus.m_icode inside {I_MRMOVQ, I_RET, I_POPQ};
        wr = bus.m_icode inside {I_RMMOVQ, I_CALL, I_PUSHQ};
        a  = (bus.m_icode inside {I_RET, I_POPQ}) ? bus.m_valA : bus.m_valE;
        err = (rd || wr) && (a > 64'(MEM_BYTES - 8));
        expM = (rd && !err) ? refRead(a) : 64'd0;
        expStat = err ? S_ADR : bus.m_status;
        wd = (bus.m_icode == I_CALL) ? bus.m_valP : bus.m_valA;
        com = wr && !err && (bus.m_status == S_AOK) && !(rStat inside {S_HLT, S_ADR, S_INS});
        #1;
        check({tag, ".mem_valM"}, bus.mem_valM, expM);
        check({tag, ".mem_stat"}, 64'(bus.mem_stat), 64'(expStat));
        @(posedge clk);
        if (com) for (int k = 0; k < 8; k++) refMem[int'(a) + k] = wd[8*k +: 8];
        if (bus.w_bubble) refResetW();
        else if (!bus.w_stall) begin
            rStat = expStat; rIcode = bus.m_icode; rValE = bus.m_valE;
            rValM = expM; rDstE = bus.m_dstE; rDstM = bus.m_dstM;
        end
        #1;
        checkW(tag);
        @(negedge clk);
    endtask

    function automatic logic [63:0] randAddr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 64'($urandom_range(0, MEM_BYTES - 1));
        else if (r < 9) return 64'(MEM_BYTES - 10 + $urandom_range(0, 4));
        else            return {$urandom, $urandom};
    endfunction

    initial begin
        logic [3:0] st;
        icodeList = '{I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                      I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ};
        refResetW();
        drive(S_AOK, I_NOP, 0, 0, 0, R_NONE, R_NONE, 1'b0, 1'b0);
        @(negedge clk);
        checkW("reset0");
        rst_n = 1'b1;
        @(negedge clk);

        // Give every byte a known value
        for (int i = 0; i < int'(MEM_BYTES / 8); i++) begin
            drive(S_AOK, I_RMMOVQ, 64'(8 * i), {$urandom, $urandom}, 0, R_NONE, R_NONE, 1'b0, 1'b0);
            stepCheck("fill");
        end

        // rmmovq then mrmovq at 0x40
        drive(S_AOK, I_RMMOVQ, 64'h40, 64'h1122334455667788, 0, R_NONE, R_NONE, 1'b0, 1'b0);
        stepCheck("rmmovq40");
        drive(S_AOK, I_MRMOVQ, 64'h40, 0, 0, R_NONE, 4'd3, 1'b0, 1'b0);
        #1;
        check("mrmovq40.word", bus.mem_valM, 64'h1122334455667788);
        check("mrmovq40.byte0", 64'(bus.mem_valM[7:0]), 64'h88);
        stepCheck("mrmovq40");
        check("mrmovq40.w_valM", bus.w_valM, 64'h1122334455667788);
        check("mrmovq40.w_dstM", 64'(bus.w_dstM), 64'd3);

        // pushq/popq and call/ret
        drive(S_AOK, I_PUSHQ, 64'h1F8, 64'd7, 0, 4'd4, R_NONE, 1'b0, 1'b0);
        stepCheck("pushq");
        drive(S_AOK, I_POPQ, 64'h200, 64'h1F8, 0, 4'd4, 4'd5, 1'b0, 1'b0);
        stepCheck("popq");
        check("popq.w_valM", bus.w_valM, 64'd7);
        drive(S_AOK, I_CALL, 64'h1F0, 0, 64'h123, 4'd4, R_NONE, 1'b0, 1'b0);
        stepCheck("call");
        drive(S_AOK, I_RET, 64'h1F8, 64'h1F0, 0, 4'd4, R_NONE, 1'b0, 1'b0);
        #1;
        check("ret.mem_valM", bus.mem_valM, 64'h123);
        stepCheck("ret");

        // Address boundaries
        drive(S_AOK, I_MRMOVQ, 64'(MEM_BYTES - 8), 0, 0, R_NONE, 4'd1, 1'b0, 1'b0);
        stepCheck("lastWord");
        drive(S_AOK, I_POPQ, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd4, 4'd1, 1'b0, 1'b0);
        #1;
        check("addrMax.mem_stat", 64'(bus.mem_stat), 64'(S_ADR));
        stepCheck("addrMax");
        drive(S_AOK, I_MRMOVQ, 64'(MEM_BYTES - 4), 0, 0, R_NONE, 4'd2, 1'b0, 1'b0);
        #1;
        check("adr.mem_stat", 64'(bus.mem_stat), 64'(S_ADR));
        stepCheck("adr");
        check("adr.w_status", 64'(bus.w_status), 64'(S_ADR));
        check("adr.w_valM", bus.w_valM, 64'd0);
        drive(S_AOK, I_RMMOVQ, 64'h40, 64'd5, 0, R_NONE, R_NONE, 1'b0, 1'b0);
        stepCheck("blockedWrite");
        drive(S_AOK, I_MRMOVQ, 64'h40, 0, 0, R_NONE, 4'd3, 1'b0, 1'b0);
        #1;
        check("reread40", bus.mem_valM, 64'h1122334455667788);
        stepCheck("reread40");

        // Stall holds, bubble beats stall
        drive(S_AOK, I_OPQ, 64'd9, 0, 0, 4'd2, R_NONE, 1'b0, 1'b0);
        stepCheck("opq");
        for (int i = 0; i < 2; i++) begin
            drive(S_AOK, I_IRMOVQ, {$urandom, $urandom}, 0, 0, 4'($urandom_range(0, 14)), R_NONE, 1'b1, 1'b0);
            stepCheck("stall");
            check("stall.w_valE", bus.w_valE, 64'd9);
            check("stall.w_dstE", 64'(bus.w_dstE), 64'd2);
        end
        drive(S_AOK, I_OPQ, 64'd77, 0, 0, 4'd6, R_NONE, 1'b1, 1'b1);
        stepCheck("bubble");
        check("bubble.w_icode", 64'(bus.w_icode), 64'(I_NOP));
        check("bubble.w_dstE", 64'(bus.w_dstE), 64'hF);

        // Write suppressed by faulty instruction status
        drive(S_INS, I_RMMOVQ, 64'h80, 64'hDEAD_BEEF, 0, R_NONE, R_NONE, 1'b0, 1'b0);
        stepCheck("insWrite");
        check("insWrite.w_status", 64'(bus.w_status), 64'(S_INS));
        drive(S_AOK, I_NOP, 0, 0, 0, R_NONE, R_NONE, 1'b0, 1'b0);
        stepCheck("clearW");
        drive(S_AOK, I_MRMOVQ, 64'h80, 0, 0, R_NONE, 4'd1, 1'b0, 1'b0);
        stepCheck("insReread");

        // Mid-cycle asynchronous reset, write on the reset edge discarded
        drive(S_AOK, I_OPQ, 64'd55, 0, 0, 4'd3, R_NONE, 1'b0, 1'b0);
        stepCheck("preReset");
        drive(S_AOK, I_RMMOVQ, 64'h100, 64'hCAFE_F00D_0000_0001, 0, R_NONE, R_NONE, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        refResetW();
        checkW("asyncReset");
        @(posedge clk);
        #1;
        checkW("inReset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(S_AOK, I_MRMOVQ, 64'h100, 0, 0, R_NONE, 4'd1, 1'b0, 1'b0);
        stepCheck("resetDiscard");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 9) < 8) ? S_AOK : 4'($urandom_range(2, 4));
            drive(st, icodeList[$urandom_range(0, 11)], randAddr(), randAddr(), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            stepCheck("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline memory stage. It sits directly downstream of the E→M pipeline register (memory_reg) and consumes that register's outputs.
- It performs data-memory reads and writes against an internal byte-addressed data memory, computes the final instruction status, and latches the results into the M→W pipeline register that feeds writeback.
- It also exposes combinational stage values for forwarding and pipeline control.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes. Must be a power of two, ≥ 8.
- AW, 64, address width. Full valE/valA width is used.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_status  in  4  status from M register (1=AOK, 2=HLT, 3=ADR, 4=INS).
- m_icode  in  4  instruction code from M register.
- m_ifun  in  4  function code from M register.
- m_valE  in  64  ALU result from M register.
- m_valA  in  64  operand A from M register.
- m_valP  in  64  next PC from M register.
- m_dstE  in  4  E destination register id (0xF = none).
- m_dstM  in  4  M destination register id (0xF = none).
- w_stall  in  1  hold W register contents.
- w_bubble  in  1  load nop bubble into W register.
- mem_valM  out  64  combinational read data (forwarding path).
- mem_stat  out  4  combinational stage status (pipeline control).
- w_status  out  4  W register status.
- w_icode  out  4  W register icode.
- w_valE  out  64  W register valE.
- w_valM  out  64  W register valM.
- w_dstE  out  4  W register dstE.
- w_dstM  out  4  W register dstM.

Behaviour:
- Address select:
  - valE for rmmovq(4), mrmovq(5), call(8), pushq(A).
  - valA for ret(9), popq(B).
  - Otherwise no access.
- Read enable: icode ∈ {5, 9, B}. Write enable: icode ∈ {4, 8, A}.
- Write data: valP for call; valA otherwise.
- Access is 8 bytes, little-endian, at addr..addr+7.
- dmem_error when an access is requested and addr > MEM_BYTES-8. The comparison is unsigned over the full 64 bits with no wrap-around, so addr = 2^64-1 is an error.
- mem_stat:
  - ADR if dmem_error.
  - Otherwise m_status.
- Reads are combinational: mem_valM = memory word when read is enabled and there is no error; otherwise 0.
- Writes commit at the rising edge only when all of the following hold:
  - write enabled;
  - no dmem_error;
  - m_status == AOK;
  - w_status ∉ {HLT, ADR, INS}.
  Writes are never gated by w_stall or w_bubble.
- W register update priority: rst_n low > w_bubble > w_stall > normal load. If both w_bubble and w_stall are high, the bubble wins.
- Normal load: W fields = {mem_stat, m_icode, m_valE, mem_valM, m_dstE, m_dstM}. Latency is 1 cycle.
- Bubble / reset values:
  - w_status=AOK(1), w_icode=nop(1);
  - w_valE=0, w_valM=0;
  - w_dstE=0xF, w_dstM=0xF.
- Reset is asynchronous: W outputs take their reset values immediately on rst_n falling, including mid-operation.
- Memory contents are not cleared by reset.
- A write asserted on the same edge as reset is discarded.
- Read-after-write to the same address in the next cycle returns the new data (the array is updated at the edge).
- m_ifun is unused except for lint-clean passthrough checks.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (HALT..POPQ);
  - status constants (AOK=1, HLT=2, ADR=3, INS=4);
  - register id NONE=0xF.
- Sub-module data_mem:
  - byte array of MEM_BYTES;
  - combinational 8-byte read;
  - synchronous 8-byte write;
  - error flag output.
- memory_stage contains the address/control decode and the W register.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle → W outputs immediately equal status 1, icode 1, valE/valM 0, dstE/dstM F.
2. rmmovq (icode 4, valE=0x40, valA=0x1122334455667788, status 1), then mrmovq (icode 5, valE=0x40, dstM=3) → mem_valM=0x1122334455667788 and, one edge later, w_valM equals it and w_dstM=3. Byte 0x40 must hold 0x88.
3. pushq/popq: pushq valE=0x1F8 valA=7, then popq valA=0x1F8 → w_valM=7. Then call valE=0x1F0 valP=0x123, then ret valA=0x1F0 → mem_valM=0x123.
4. Address error: mrmovq valE=MEM_BYTES-4 → mem_stat=3 and, after the edge, w_status=3, w_valM=0. A subsequent rmmovq to 0x40 with value 5 does not change memory (re-read of 0x40 still returns the old value).
5. Stall/bubble: load OPq (valE=9, dstE=2), then hold w_stall=1 for 2 cycles while inputs change → W still holds 9/2. Then w_bubble=1 together with w_stall=1 → nop bubble.
6. Suppressed write: rmmovq with m_status=INS(4) → memory unchanged and w_status=4.
